// File: rtl/expr_push_cc_if.sv
// Token, stack and calculation-handshake signals of the expression push controller.
// master = the controller, slave = token source, stacks and calculation controller.
interface expr_push_cc_if #(
  parameter int DATA_W = 8
);
  logic              tok_valid;
  logic              tok_ready;
  logic [2:0]        tok_type;
  logic [DATA_W-1:0] tok_data;
  logic              opndSTK_push;
  logic [DATA_W-1:0] opnd_din;
  logic              opSTK_push;
  logic [2:0]        op_din;
  logic              opSTK_pop;
  logic [2:0]        op_top;
  logic              op_empty;
  logic              calc_start;
  logic              calc_complete;
  logic              done;
  logic              error;

  modport master (
    input  tok_valid, tok_type, tok_data, op_top, op_empty, calc_complete,
    output tok_ready, opndSTK_push, opnd_din, opSTK_push, op_din, opSTK_pop,
           calc_start, done, error
  );

  modport slave (
    output tok_valid, tok_type, tok_data, op_top, op_empty, calc_complete,
    input  tok_ready, opndSTK_push, opnd_din, opSTK_push, op_din, opSTK_pop,
           calc_start, done, error
  );
endinterface

// File: rtl/expr_push_cc.sv
// Shunting-yard token controller: pushes operands/operators and requests a
// reduction from the calculation controller whenever precedence demands one.
module expr_push_cc #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  expr_push_cc_if.master bus
);

  localparam logic [2:0] T_NUM = 3'b000;
  localparam logic [2:0] T_OP  = 3'b001;
  localparam logic [2:0] T_LP  = 3'b010;
  localparam logic [2:0] T_RP  = 3'b011;
  localparam logic [2:0] T_END = 3'b100;
  localparam logic [2:0] PAREN = 3'b100;

  typedef enum logic [3:0] {
    S_ACCEPT, S_PUSH_OPND, S_CMP_OP, S_PUSH_OP, S_CMP_RP, S_POP_PAREN,
    S_CMP_END, S_CALC_START, S_CALC_WAIT, S_DONE, S_ERR
  } state_t;

  state_t            state_q, ret_q;
  logic [1:0]        code_q;
  logic              tok_ready_q, opnd_push_q, op_push_q, op_pop_q;
  logic              calc_start_q, done_q, error_q;
  logic [DATA_W-1:0] opnd_din_q;
  logic [2:0]        op_din_q;

  // Incoming operator reduces the stack top when top is a real operator of
  // equal or higher precedence (left associativity).
  logic reduce_op;
  assign reduce_op = !bus.op_empty && !bus.op_top[2] && (bus.op_top[1] >= code_q[1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_ACCEPT;
      ret_q        <= S_CMP_OP;
      code_q       <= 2'b00;
      tok_ready_q  <= 1'b1;
      opnd_push_q  <= 1'b0;
      op_push_q    <= 1'b0;
      op_pop_q     <= 1'b0;
      calc_start_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      opnd_din_q   <= '0;
      op_din_q     <= 3'b000;
    end else begin
      opnd_push_q  <= 1'b0;
      op_push_q    <= 1'b0;
      op_pop_q     <= 1'b0;
      calc_start_q <= 1'b0;
      case (state_q)
        S_ACCEPT: begin
          if (bus.tok_valid) begin
            tok_ready_q <= 1'b0;
            case (bus.tok_type)
              T_NUM: begin
                opnd_din_q  <= bus.tok_data;
                opnd_push_q <= 1'b1;
                state_q     <= S_PUSH_OPND;
              end
              T_OP: begin
                code_q  <= bus.tok_data[1:0];
                state_q <= S_CMP_OP;
              end
              T_LP: begin
                op_din_q  <= PAREN;
                op_push_q <= 1'b1;
                state_q   <= S_PUSH_OP;
              end
              T_RP:  state_q <= S_CMP_RP;
              T_END: state_q <= S_CMP_END;
              default: begin
                error_q <= 1'b1;
                state_q <= S_ERR;
              end
            endcase
          end
        end
        S_PUSH_OPND, S_PUSH_OP, S_POP_PAREN: begin
          tok_ready_q <= 1'b1;
          state_q     <= S_ACCEPT;
        end
        S_CMP_OP: begin
          if (reduce_op) begin
            calc_start_q <= 1'b1;
            ret_q        <= S_CMP_OP;
            state_q      <= S_CALC_START;
          end else begin
            op_din_q  <= {1'b0, code_q};
            op_push_q <= 1'b1;
            state_q   <= S_PUSH_OP;
          end
        end
        S_CMP_RP: begin
          if (bus.op_empty) begin
            error_q <= 1'b1;
            state_q <= S_ERR;
          end else if (bus.op_top == PAREN) begin
            op_pop_q <= 1'b1;
            state_q  <= S_POP_PAREN;
          end else begin
            calc_start_q <= 1'b1;
            ret_q        <= S_CMP_RP;
            state_q      <= S_CALC_START;
          end
        end
        S_CMP_END: begin
          if (bus.op_empty) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (bus.op_top == PAREN) begin
            error_q <= 1'b1;
            state_q <= S_ERR;
          end else begin
            calc_start_q <= 1'b1;
            ret_q        <= S_CMP_END;
            state_q      <= S_CALC_START;
          end
        end
        S_CALC_START: state_q <= S_CALC_WAIT;
        // Stack tops are re-evaluated in the compare state after completion.
        S_CALC_WAIT: if (bus.calc_complete) state_q <= ret_q;
        S_DONE: begin
          if (bus.tok_valid && bus.tok_type == T_END) begin
            done_q      <= 1'b0;
            tok_ready_q <= 1'b1;
            state_q     <= S_ACCEPT;
          end
        end
        S_ERR: state_q <= S_ERR;
        default: begin
          tok_ready_q <= 1'b1;
          state_q     <= S_ACCEPT;
        end
      endcase
    end
  end

  assign bus.tok_ready    = tok_ready_q;
  assign bus.opndSTK_push = opnd_push_q;
  assign bus.opnd_din     = opnd_din_q;
  assign bus.opSTK_push   = op_push_q;
  assign bus.op_din       = op_din_q;
  assign bus.opSTK_pop    = op_pop_q;
  assign bus.calc_start   = calc_start_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_expr_push_cc.sv
// Directed bench for expr_push_cc with an operator-stack model and a
// calculation controller that completes a fixed number of cycles after start.
module tb_expr_push_cc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  expr_push_cc_if #(.DATA_W(8)) bus ();
  expr_push_cc #(.DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Operator stack model plus calculation responder; everything sampled on negedge.
  logic [2:0] stk [0:15];
  int         depth = 0;
  int         cd = 0;
  int         calc_lat = 3;
  logic       cc_auto = 1'b0;
  logic       cc_force = 1'b0;
  int         excl_viol = 0;
  int unsigned log_q [$];
  int unsigned exp_q [$];

  assign bus.op_empty      = (depth == 0);
  assign bus.op_top        = (depth > 0) ? stk[depth-1] : 3'b000;
  assign bus.calc_complete = cc_auto | cc_force;

  always @(negedge clk) begin
    if (reset) begin
      depth   <= 0;
      cd      <= 0;
      cc_auto <= 1'b0;
    end else begin
      if (int'(bus.opndSTK_push) + int'(bus.opSTK_push) + int'(bus.opSTK_pop)
          + int'(bus.calc_start) > 1)
        excl_viol <= excl_viol + 1;
      if (bus.opndSTK_push) log_q.push_back(32'h100 | 32'(bus.opnd_din));
      if (bus.opSTK_push) begin
        log_q.push_back(32'h200 | 32'(bus.op_din));
        stk[depth] <= bus.op_din;
        depth      <= depth + 1;
      end
      if (bus.opSTK_pop) begin
        log_q.push_back(32'h300);
        if (depth > 0) depth <= depth - 1;
      end
      cc_auto <= 1'b0;
      if (bus.calc_start) begin
        log_q.push_back(32'h400);
        cd <= calc_lat;
      end else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          cc_auto <= 1'b1;
          if (depth > 0) depth <= depth - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_log(input string tag, input int base);
    chk({tag, "_len"}, 32'(log_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < log_q.size())
        chk($sformatf("%s_ev%0d", tag, i), log_q[base+i], exp_q[i]);
  endtask

  task automatic send(input logic [2:0] t, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.tok_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("tok_ready_timeout", 32'(bus.tok_ready), 32'd1);
    bus.tok_valid = 1'b1;
    bus.tok_type  = t;
    bus.tok_data  = d;
    @(negedge clk);
    bus.tok_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && !bus.error && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_error"}, 32'(bus.error), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus.tok_ready), 32'd1);
    chk({tag, "_strobes"}, 32'({bus.opndSTK_push, bus.opSTK_push, bus.opSTK_pop,
                                bus.calc_start}), 32'd0);
    chk({tag, "_flags"}, 32'({bus.done, bus.error}), 32'd0);
  endtask

  localparam logic [2:0] NUM = 3'd0, OP = 3'd1, LP = 3'd2, RP = 3'd3, EN = 3'd4;

  initial begin
    int base;
    int starts;
    bus.tok_valid = 1'b0;
    bus.tok_type  = 3'd0;
    bus.tok_data  = 8'd0;

    // Reset state
    @(negedge clk);
    check_idle("reset");
    chk("reset_opnd_din", 32'(bus.opnd_din), 32'd0);
    chk("reset_op_din", 32'(bus.op_din), 32'd0);
    reset = 1'b0;

    // 2 + 3 * 4 end : both reductions happen on end
    base = log_q.size();
    send(NUM, 8'd2); send(OP, 8'd0); send(NUM, 8'd3); send(OP, 8'd2);
    send(NUM, 8'd4); send(EN, 8'd0);
    wait_done("t1");
    exp_q = '{32'h102, 32'h200, 32'h103, 32'h202, 32'h104, 32'h400, 32'h400};
    check_log("t1", base);

    // end token while done starts a new expression
    @(negedge clk);
    bus.tok_valid = 1'b1; bus.tok_type = EN;
    @(negedge clk);
    bus.tok_valid = 1'b0;
    check_idle("t1_restart");

    // 2 * 3 + 4 end : '*' reduces when '+' arrives
    do_reset();
    base = log_q.size();
    send(NUM, 8'd2); send(OP, 8'd2); send(NUM, 8'd3); send(OP, 8'd0);
    send(NUM, 8'd4); send(EN, 8'd0);
    wait_done("t2");
    exp_q = '{32'h102, 32'h202, 32'h103, 32'h400, 32'h200, 32'h104, 32'h400};
    check_log("t2", base);

    // ( 2 + 3 ) * 4 end
    do_reset();
    base = log_q.size();
    send(LP, 8'd0); send(NUM, 8'd2); send(OP, 8'd0); send(NUM, 8'd3);
    send(RP, 8'd0); send(OP, 8'd2); send(NUM, 8'd4); send(EN, 8'd0);
    wait_done("t3");
    exp_q = '{32'h204, 32'h102, 32'h200, 32'h103, 32'h400, 32'h300,
              32'h202, 32'h104, 32'h400};
    check_log("t3", base);

    // ')' on an empty operator stack
    do_reset();
    base = log_q.size();
    send(RP, 8'd0);
    chk("t4_err_before", 32'(bus.error), 32'd0);
    @(negedge clk);
    chk("t4_err", 32'(bus.error), 32'd1);
    bus.tok_valid = 1'b1; bus.tok_type = NUM; bus.tok_data = 8'd9;
    repeat (5) @(negedge clk);
    bus.tok_valid = 1'b0;
    chk("t4_ready", 32'(bus.tok_ready), 32'd0);
    chk("t4_err_sticky", 32'(bus.error), 32'd1);
    exp_q = '{};
    check_log("t4", base);

    // ( 2 end : unmatched parenthesis
    do_reset();
    base = log_q.size();
    send(LP, 8'd0); send(NUM, 8'd2); send(EN, 8'd0);
    repeat (3) @(negedge clk);
    chk("t5_err", 32'(bus.error), 32'd1);
    chk("t5_done", 32'(bus.done), 32'd0);
    exp_q = '{32'h204, 32'h102};
    check_log("t5", base);

    // Reset during CALC_WAIT, late complete ignored, then 5 end
    do_reset();
    calc_lat = 1000;
    base = log_q.size();
    send(NUM, 8'd2); send(OP, 8'd2); send(NUM, 8'd3); send(OP, 8'd0);
    repeat (4) @(negedge clk);
    starts = 0;
    foreach (log_q[i]) if (i >= base && log_q[i] == 32'h400) starts++;
    chk("t6_started", 32'(starts), 32'd1);
    chk("t6_waiting", 32'(bus.tok_ready), 32'd0);
    #2 reset = 1'b1;
    #1 check_idle("t6_async_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    calc_lat = 3;
    cc_force = 1'b1;
    @(negedge clk);
    cc_force = 1'b0;
    @(negedge clk);
    check_idle("t6_late_cc");
    base = log_q.size();
    send(NUM, 8'd5); send(EN, 8'd0);
    wait_done("t6");
    exp_q = '{32'h105};
    check_log("t6", base);

    chk("strobe_excl", 32'(excl_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_push_cc.md
Name: expr_push_CC

Overview:
- Token-side controller for the expression calculator; the initiator that feeds both stacks and drives the `start`/`complete` handshake of the calculation controller.
- Accepts a token stream of numbers, operators, parentheses and end.
- Pushes operands onto the operand stack and operators onto the operator stack, using shunting-yard precedence.
- Each time a reduction is needed, issues `calc_start` and waits for `calc_complete`.

Parameters:
- DATA_W, 8, width of operand tokens and operand-stack data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- tok_valid  input  1  token present on tok_type/tok_data.
- tok_ready  output  1  controller can accept a token this cycle.
- tok_type  input  3  000 number, 001 operator, 010 '(', 011 ')', 100 end; others illegal.
- tok_data  input  DATA_W  number value, or operator code in [1:0]: 00 +, 01 -, 10 *, 11 /.
- opndSTK_push  output  1  one-cycle push strobe to operand stack.
- opnd_din  output  DATA_W  operand pushed (registered copy of tok_data).
- opSTK_push  output  1  one-cycle push strobe to operator stack.
- op_din  output  3  operator entry: {0,code} for operators, 3'b100 for '('.
- opSTK_pop  output  1  one-cycle pop strobe, used only to discard '('.
- op_top  input  3  current operator-stack top; valid when op_empty=0.
- op_empty  input  1  operator stack empty.
- calc_start  output  1  one-cycle start pulse to the calculation controller.
- calc_complete  input  1  calculation controller finished one reduction.
- done  output  1  level; expression fully reduced.
- error  output  1  level; sticky malformed-expression flag.

Behaviour:
- Reset: state=ACCEPT; every output 0 except tok_ready=1. opnd_din=0, op_din=0.
- Precedence: code[1]. '*' and '/' are high; '+' and '-' are low.
- tok_ready=1 only in ACCEPT. A token is taken when tok_valid&tok_ready.
- ACCEPT:
  - number → PUSH_OPND.
  - operator → latch code, go CMP_OP.
  - '(' → PUSH_OP with op_din=3'b100.
  - ')' → CMP_RP.
  - end → CMP_END.
  - illegal type → ERR.
- PUSH_OPND: opndSTK_push=1 for one cycle, then ACCEPT. Latency token→push is 1 cycle.
- CMP_OP:
  - If !op_empty and op_top[2]==0 and op_top[1]>=code[1] → CALC_START.
  - Otherwise → PUSH_OP with op_din={0,code}.
  - Left-associative: equal precedence reduces first.
- PUSH_OP: opSTK_push=1 for one cycle, then ACCEPT.
- CMP_RP:
  - op_empty → ERR.
  - op_top==3'b100 → POP_PAREN.
  - Otherwise → CALC_START.
- POP_PAREN: opSTK_pop=1 for one cycle, then ACCEPT.
- CMP_END:
  - op_empty → DONE.
  - op_top==3'b100 (unmatched '(') → ERR.
  - Otherwise → CALC_START.
- CALC_START: calc_start=1 for exactly one cycle, then CALC_WAIT.
- CALC_WAIT:
  - Hold until calc_complete=1, then return to the originating compare state (CMP_OP, CMP_RP or CMP_END) via a registered return tag.
  - Stack tops are re-read in the compare state, one cycle after complete.
- calc_complete outside CALC_WAIT is ignored.
- DONE: done=1, tok_ready=0. Stays until reset or a tok_valid with tok_type=end, which clears done and returns to ACCEPT for a new expression.
- ERR: error=1, tok_ready=0. All strobes are 0. Left only by reset.
- Push and pop strobes are mutually exclusive and never overlap calc_start.
- At most one strobe is asserted per cycle.
- Reset mid-operation (including during CALC_WAIT) aborts immediately to ACCEPT. Stack contents are the stacks' own responsibility.
- Stack full/empty for operands is not checked here.

Test Plan:
- Tokens 2,+,3,*,4,end, calc_complete returned 3 cycles after each start:
  - operand pushes 2,3,4;
  - op pushes 000 then 010;
  - exactly 2 calc_start pulses, both after end;
  - done=1.
- Tokens 2,*,3,+,4,end:
  - one calc_start before op push of 000 (the '*' reduces on '+');
  - total 2 starts;
  - done=1.
- Tokens (,2,+,3,),*,4,end:
  - op_din 100 pushed;
  - on ')' one calc_start then opSTK_pop;
  - total starts 2;
  - done=1;
  - error=0.
- Token ')' with op_empty=1 → error=1 next cycle; tok_ready=0 thereafter; no strobes.
- Tokens (,2,end → error=1 with no calc_start.
- Assert reset during CALC_WAIT:
  - all outputs clear asynchronously; tok_ready=1 after release;
  - a late calc_complete is ignored;
  - new expression 5,end → one opnd push of 5; done=1.
